// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared types and constants for the ping-pong scanout block.
//   bank_state_t   : life cycle of one frame bank
//   reader_state_t : raster reader FSM states
//   scan_mark_t    : per-position markers carried down the scan pipeline
//   SCAN_LAT       : counter position -> registered output latency
package pingpong_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
  typedef enum logic {IDLE, SCAN} reader_state_t;

  typedef struct packed {
    logic vld;
    logic ls;
    logic fs;
    logic ur;
  } scan_mark_t;

  localparam int SCAN_LAT = 2;
endpackage

// File: rtl/pingpong_bank_ram.sv
// pingpong_bank_ram: two frame banks in one array, bank select is the
// address MSB. One write port, one registered read port.
//   clk     : clock
//   i_we    : write enable          i_waddr/i_wdata : write address/data
//   i_re    : read enable           i_raddr         : read address
//   o_rdata : read data, valid the cycle after i_re, held otherwise
module pingpong_bank_ram #(
  parameter int WORD_W = 32,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW:0]       i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW:0]       i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [0:(2<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/pingpong_scanout.sv
// pingpong_scanout: double-buffers packed pixel words into two banks and
// scans the completed bank out as a raster with programmable timing.
//   clk, reset                : clock, synchronous active-high reset
//   WData/WValid/WReady       : word write handshake (pixel 0 in LSBs)
//   Buf0Empty/Buf1Empty       : bank is EMPTY
//   CSDisplay                 : display enable
//   HBOut_PD/VBOut_PD         : horizontal/vertical blank counts
//   AIPOut_PD/AILOut_PD       : active pixels per line / lines per frame
//   PixOut/PixValid           : output pixel and its qualifier
//   LineStart/FrameStart      : markers on first pixel of line / frame
//   Underrun                  : frame started with no FULL bank
module pingpong_scanout
  import pingpong_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int PIX_W       = 8,
  parameter int DEPTH_WORDS = 4096,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] WData,
  input  logic              WValid,
  output logic              WReady,
  output logic              Buf0Empty,
  output logic              Buf1Empty,
  input  logic              CSDisplay,
  input  logic [CNT_W-1:0]  HBOut_PD,
  input  logic [CNT_W-1:0]  VBOut_PD,
  input  logic [CNT_W-1:0]  AIPOut_PD,
  input  logic [CNT_W-1:0]  AILOut_PD,
  output logic [PIX_W-1:0]  PixOut,
  output logic              PixValid,
  output logic              LineStart,
  output logic              FrameStart,
  output logic              Underrun
);
  localparam int PPW  = WORD_W / PIX_W;
  localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int FW_W = 2 * CNT_W;
  localparam int HW   = CNT_W + 1;
  localparam int LW   = (PPW > 1) ? $clog2(PPW) : 1;

  bank_state_t r_bank_st [2];

  // ---------------- writer ----------------
  logic              r_wr_bank;
  logic [FW_W-1:0]   r_wr_cnt, r_wr_fw;
  logic [FW_W-1:0]   w_area, w_fw_live, w_wr_fw, w_wr_idx;
  bank_state_t       w_wst;
  logic              w_wr_fire, w_wr_last;

  assign w_area    = FW_W'(AIPOut_PD) * FW_W'(AILOut_PD);
  assign w_fw_live = w_area / FW_W'(PPW);
  assign w_wst     = r_bank_st[r_wr_bank];
  // An EMPTY bank tracks the live frame size; it is frozen on the first word.
  assign w_wr_fw   = (w_wst == EMPTY) ? w_fw_live : r_wr_fw;
  assign w_wr_idx  = (w_wst == EMPTY) ? '0 : r_wr_cnt;
  assign WReady    = ((w_wst == EMPTY) && (w_fw_live != '0)) || (w_wst == FILLING);
  assign w_wr_fire = WValid && WReady;
  assign w_wr_last = (w_wr_idx + FW_W'(1)) == w_wr_fw;
  assign Buf0Empty = r_bank_st[0] == EMPTY;
  assign Buf1Empty = r_bank_st[1] == EMPTY;

  // ---------------- reader ----------------
  reader_state_t     r_rd_st, w_rd_nxt;
  logic [HW-1:0]     r_h, r_v, w_hmax, w_vmax;
  logic [CNT_W-1:0]  r_aip, r_ail, r_hb, r_vb;
  logic              r_rd_active, r_rd_bank, r_rd_next;
  logic [AW-1:0]     r_rd_addr, w_rd_addr;
  logic [LW-1:0]     r_lane;
  logic              w_go, w_eof, w_start, w_fs, w_sel_ok, w_frame_ok;
  logic              w_rd_bank, w_in_act, w_act, w_re, w_last;

  assign w_hmax     = HW'(r_aip) + HW'(r_hb) - HW'(1);
  assign w_vmax     = HW'(r_ail) + HW'(r_vb) - HW'(1);
  assign w_go       = CSDisplay && (AIPOut_PD != '0) && (AILOut_PD != '0);
  assign w_eof      = (r_rd_st == SCAN) && (r_h == w_hmax) && (r_v == w_vmax);
  assign w_start    = w_go && ((r_rd_st == IDLE) || w_eof);
  assign w_fs       = (r_rd_st == SCAN) && (r_h == '0) && (r_v == '0);
  // Banks are filled and read in strict alternation, so the oldest FULL
  // bank is always the one after the last bank read.
  assign w_sel_ok   = r_bank_st[r_rd_next] == FULL;
  assign w_frame_ok = w_fs ? w_sel_ok : r_rd_active;
  assign w_rd_bank  = w_fs ? r_rd_next : r_rd_bank;
  assign w_in_act   = (r_rd_st == SCAN) && (r_h < HW'(r_aip)) && (r_v < HW'(r_ail));
  assign w_act      = w_in_act && w_frame_ok;
  assign w_re       = w_act && (r_lane == '0);
  assign w_rd_addr  = w_fs ? '0 : r_rd_addr;
  assign w_last     = w_act && (r_h == HW'(r_aip) - HW'(1)) && (r_v == HW'(r_ail) - HW'(1));

  always_ff @(posedge clk) begin
    if (reset) r_rd_st <= IDLE;
    else       r_rd_st <= w_rd_nxt;
  end

  // Enable is only sampled at frame boundaries; a frame always completes.
  always_comb begin
    w_rd_nxt = r_rd_st;
    case (r_rd_st)
      IDLE:    if (w_go) w_rd_nxt = SCAN;
      SCAN:    if (w_eof && !w_go) w_rd_nxt = IDLE;
      default: w_rd_nxt = IDLE;
    endcase
  end

  // ---------------- RAM ----------------
  logic [WORD_W-1:0] w_ram_q;

  pingpong_bank_ram #(.WORD_W(WORD_W), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr ({r_wr_bank, w_wr_idx[AW-1:0]}),
    .i_wdata (WData),
    .i_re    (w_re),
    .i_raddr ({w_rd_bank, w_rd_addr}),
    .o_rdata (w_ram_q)
  );

  // ---------------- sequential state ----------------
  scan_mark_t        r_s1;
  logic [LW-1:0]     r_s1_lane;
  // Bank release trails the last active position by SCAN_LAT so the bank
  // goes EMPTY the cycle after its last pixel leaves the output register.
  logic [SCAN_LAT-1:0] r_rel_pipe, r_rel_bank;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) r_bank_st[b] <= EMPTY;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_wr_fw     <= '0;
      r_h         <= '0;
      r_v         <= '0;
      r_aip       <= '0;
      r_ail       <= '0;
      r_hb        <= '0;
      r_vb        <= '0;
      r_rd_active <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_next   <= 1'b0;
      r_rd_addr   <= '0;
      r_lane      <= '0;
      r_s1        <= '0;
      r_s1_lane   <= '0;
      r_rel_pipe  <= '0;
      r_rel_bank  <= '0;
      PixOut      <= '0;
      PixValid    <= 1'b0;
      LineStart   <= 1'b0;
      FrameStart  <= 1'b0;
      Underrun    <= 1'b0;
    end else begin
      // Writer, reader claim and release always target different banks.
      for (int b = 0; b < 2; b++) begin
        if (w_wr_fire && (r_wr_bank == 1'(b)))
          r_bank_st[b] <= w_wr_last ? FULL : FILLING;
        else if (w_fs && w_sel_ok && (r_rd_next == 1'(b)))
          r_bank_st[b] <= READING;
        else if (r_rel_pipe[SCAN_LAT-1] && (r_rel_bank[SCAN_LAT-1] == 1'(b)))
          r_bank_st[b] <= EMPTY;
      end
      if (w_wr_fire) begin
        r_wr_cnt <= w_wr_last ? '0 : w_wr_idx + FW_W'(1);
        r_wr_fw  <= w_wr_fw;
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end

      if (w_start) begin
        r_h   <= '0;
        r_v   <= '0;
        r_aip <= AIPOut_PD;
        r_ail <= AILOut_PD;
        r_hb  <= HBOut_PD;
        r_vb  <= VBOut_PD;
      end else if (r_rd_st == SCAN) begin
        if (r_h == w_hmax) begin
          r_h <= '0;
          r_v <= (r_v == w_vmax) ? '0 : r_v + HW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
      if (w_fs) begin
        r_rd_active <= w_sel_ok;
        r_rd_bank   <= r_rd_next;
        if (w_sel_ok) r_rd_next <= ~r_rd_next;
      end
      r_rd_addr <= w_rd_addr + AW'(w_re);
      // AIP is a multiple of PPW, so the lane is back at 0 at every line end.
      r_lane    <= (w_act && (r_lane != LW'(PPW - 1))) ? r_lane + LW'(1) : '0;

      r_s1.vld   <= w_act;
      r_s1.ls    <= w_act && (r_h == '0);
      r_s1.fs    <= w_act && w_fs;
      r_s1.ur    <= w_fs && !w_sel_ok;
      r_s1_lane  <= r_lane;
      r_rel_pipe <= {r_rel_pipe[SCAN_LAT-2:0], w_last};
      r_rel_bank <= {r_rel_bank[SCAN_LAT-2:0], w_rd_bank};

      PixValid   <= r_s1.vld;
      PixOut     <= r_s1.vld ? w_ram_q[r_s1_lane*PIX_W +: PIX_W] : '0;
      LineStart  <= r_s1.ls;
      FrameStart <= r_s1.fs;
      Underrun   <= r_s1.ur;
    end
  end
endmodule

// File: doc/pingpong_scanout.md
Name: pingpong_scanout

Overview:
Parametrised successor to the single-format display datapath. It double-buffers packed pixel words written by the image source into two banks, then scans the completed bank out as a raster. The raster has programmable active-pixel, active-line, horizontal-blank and vertical-blank counts. It sits between the image reader (word producer) and the display panel interface, and adds a valid/ready write handshake, word-to-pixel unpacking, frame/line markers and underrun detection.

Parameters:
WORD_W, 32, width of each packed write word.
PIX_W, 8, pixel width; WORD_W must be a multiple of PIX_W; PPW = WORD_W/PIX_W pixels per word.
DEPTH_WORDS, 4096, words per bank.
CNT_W, 10, width of all timing counters and timing inputs.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
WData  in  WORD_W  packed pixel word; pixel 0 is in the LSBs
WValid  in  1  WData is valid this cycle
WReady  out  1  block accepts WData; a transfer occurs when WValid&WReady
Buf0Empty  out  1  bank 0 is EMPTY
Buf1Empty  out  1  bank 1 is EMPTY
CSDisplay  in  1  display enable
HBOut_PD  in  CNT_W  horizontal blank cycles per line
VBOut_PD  in  CNT_W  vertical blank lines per frame
AIPOut_PD  in  CNT_W  active pixels per line; must be a multiple of PPW
AILOut_PD  in  CNT_W  active lines per frame
PixOut  out  PIX_W  output pixel
PixValid  out  1  PixOut is an active pixel
LineStart  out  1  one-cycle pulse aligned with the first active pixel of each line
FrameStart  out  1  one-cycle pulse aligned with pixel (0,0)
Underrun  out  1  one-cycle pulse when a frame starts with no FULL bank

Behaviour:
- Reset values: WReady=1, Buf0Empty=1, Buf1Empty=1, PixOut=0, PixValid=0, LineStart=0, FrameStart=0, Underrun=0. Both banks are EMPTY, the write bank is 0 and the reader is IDLE. Reset asserted mid-operation aborts everything to these values on the next edge.
- FRAME_WORDS = AIPOut_PD*AILOut_PD/PPW. It is latched together with all four timing inputs when writing of a bank begins (writer) or when a frame starts (reader). Inputs changed mid-frame have no effect until the next latch point. FRAME_WORDS > DEPTH_WORDS is a configuration error and behaviour is undefined.
- Bank states: EMPTY -> FILLING on the first accepted word -> FULL on the FRAME_WORDS-th accepted word -> READING at frame start -> EMPTY one cycle after the last active pixel of that frame.
- Writer: targets wr_bank, and WReady = wr_bank is EMPTY or FILLING. On FULL, wr_bank toggles. If the other bank is not EMPTY, WReady=0 until it becomes EMPTY. Writer and reader never touch the same bank.
- Reader FSM:
  - IDLE: holds while CSDisplay=0; moves to SCAN when CSDisplay=1.
  - SCAN: horizontal counter h runs 0..AIP+HB-1; vertical counter v runs 0..AIL+VB-1. Active region is h<AIP and v<AIL.
  - Frame start is h=0, v=0. The reader then selects the oldest FULL bank and marks it READING. If no bank is FULL, it pulses Underrun, drives PixValid=0 for the whole frame, and retries at the next frame start.
  - At the end of a frame (last cycle of v=AIL+VB-1), it returns to IDLE if CSDisplay=0. Otherwise it continues. Dropping CSDisplay mid-frame never truncates the frame.
- Unpacking: one word read per PPW active pixels; pixel k of the word = WData[k*PIX_W +: PIX_W].
- Latency: PixOut, PixValid, LineStart and FrameStart are registered 2 cycles after the counter position that generates them (1 cycle memory read, 1 cycle output register). Underrun has the same 2-cycle alignment.
- PixOut is 0 whenever PixValid=0.
- AIPOut_PD=0 or AILOut_PD=0 latched: the reader stays IDLE, and the writer treats the frame as 0 words (WReady=0).
- Simultaneous write completion and read release of different banks in one cycle: both take effect.

Decomposition:
- Package pingpong_pkg: bank_state_t enum (EMPTY/FILLING/FULL/READING), reader_state_t (IDLE/SCAN), output latency constant SCAN_LAT=2.
- Sub-module pingpong_bank_ram: dual-port RAM of 2*DEPTH_WORDS x WORD_W, with one write port, one registered read port and bank select as the address MSB.

Test Plan:
- Reset: assert reset for 2 cycles -> all outputs at reset values, Buf0Empty=Buf1Empty=1, WReady=1.
- Fill: WORD_W=32, PIX_W=8, AIP=8, AIL=2, HB=2, VB=1; write 4 words 0x03020100..0x0F0E0D0C -> Buf0Empty=0, wr_bank=1, WReady=1.
- Scan: CSDisplay=1 -> FrameStart, then PixOut 0x00..0x07 with PixValid; 2 blank cycles; next line 0x08..0x0F with LineStart; Buf0Empty=1 after the last pixel; frame length 30 cycles.
- Backpressure: both banks filled while bank 0 is READING -> WReady=0 until bank 0 returns to EMPTY, then writes resume into bank 0.
- Underrun: CSDisplay=1 with both banks EMPTY -> Underrun pulses once per frame start, PixValid stays 0, and scanning recovers on the first frame start after a bank becomes FULL.
- Mid-frame events: CSDisplay dropped at v=1 -> frame completes, then IDLE. Reset asserted mid-frame -> next cycle all outputs at reset values, both banks EMPTY.
